ahb_lite_sram_bridge: RTL and testbench
=======================================

Name: ahb_lite_sram_bridge

Overview:
- AHB-Lite slave that maps a 16 KB window onto a single-port synchronous 32-bit SRAM macro: 4096 words, byte write enables, 1-cycle read latency.
- Sits on the system AHB bus as the data/instruction RAM slave, beside the flash XIP controller and GPIO.
- Zero wait states, except one stall cycle when a read address phase collides with a pending write.

Parameters:
- AW, 14, byte-address width decoded (SRAMADDR width = AW-2 = 12).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from bus decoder.
- HADDR  in  32  byte address; only [AW-1:0] used.
- HREADY  in  1  bus-wide ready; transfer sampled only when high.
- HWRITE  in  1  1 = write.
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HWDATA  in  32  write data, data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- SRAMRDATA  in  32  SRAM read data, valid the cycle after a read is issued.
- SRAMWEN  out  4  per-byte write enables; bit i = byte lane i (bits [8i+7:8i]).
- SRAMWDATA  out  32  SRAM write data.
- SRAMCS0  out  1  SRAM chip select.
- SRAMADDR  out  12  SRAM word address.

Behaviour:
- Transfer accepted: acc = HSEL & HREADY & HTRANS[1]. IDLE/BUSY and unselected cycles are ignored.
- Byte-lane mask from HSIZE/HADDR[1:0]:
  - byte → 1 << HADDR[1:0]
  - halfword → 4'b0011 or 4'b1100, chosen by HADDR[1]
  - word (or any HSIZE ≥ 2) → 4'b1111
  - Misalignment is not checked; low address bits beyond the size are ignored.
- Write, address phase (acc & HWRITE): register wr_pend=1, wr_addr = HADDR[AW-1:2], wr_mask.
- Write, data phase (wr_pend=1):
  - Drive SRAMCS0=1, SRAMADDR=wr_addr, SRAMWEN=wr_mask, SRAMWDATA=HWDATA.
  - The SRAM write happens at that clock edge; clear wr_pend unless a new write is accepted in the same cycle.
- Read, address phase (acc & ~HWRITE), no write pending:
  - Drive combinationally SRAMCS0=1, SRAMADDR=HADDR[AW-1:2], SRAMWEN=0.
  - Register rd_pend=1.
- Read, data phase (rd_pend=1): HRDATA = SRAMRDATA, HREADYOUT=1, so a read completes with zero wait states.
- Collision (wr_pend=1 and a read address phase present, i.e. HSEL & HTRANS[1] & ~HWRITE):
  - Write has priority on the SRAM port.
  - HREADYOUT=0 for that cycle, extending the write data phase; the master holds the address and HWDATA.
  - Set stall flag; the write is performed in the first stalled cycle only. SRAMWEN must be 0 in the following cycle, so no double write.
  - Next cycle: HREADYOUT=1, the held read address is issued to SRAM, rd_pend set on acceptance; data returns the cycle after.
- Back-to-back writes: each write occupies its own data phase; no stall.
- Write followed by read of the same address, even with the collision stall: the read must return the new data.
- Idle outputs:
  - SRAMCS0=0, SRAMWEN=0.
  - SRAMWDATA=HWDATA (don't-care while WEN=0).
  - HRDATA = SRAMRDATA when rd_pend, else 0.
- Addresses ≥ 2^AW alias (wrap) modulo 16 KB.
- Error responses are never generated.
- Reset (HRESET=1 at edge): wr_pend=0, rd_pend=0, stall=0 → HREADYOUT=1, SRAMCS0=0, SRAMWEN=0, HRDATA=0.
- Reset mid-transfer discards any pending write (no SRAM write occurs after reset is asserted).

Test Plan:
- Reset: hold HRESET 2 cycles → HREADYOUT=1, SRAMCS0=0, SRAMWEN=0; a write in flight before reset never reaches SRAM.
- Word write/read: write 0xDEADBEEF to 0x0000_0010, then read 0x10:
  - write data phase shows SRAMADDR=0x004, SRAMWEN=4'hF, SRAMCS0=1;
  - read stalls exactly 1 cycle (HREADYOUT=0), then HRDATA=0xDEADBEEF.
- Byte/halfword lanes: byte writes to 0x21, 0x22 → SRAMWEN=4'b0010, 4'b0100; halfword to 0x22 → 4'b1100; read of 0x20 after preload 0x11223344 with byte 0xAA at 0x21 → 0x1122AA44.
- Pipelined reads: reads of 0x0, 0x4, 0x8 with HTRANS NONSEQ,SEQ,SEQ → HREADYOUT stays 1; each HRDATA valid the cycle after its address phase.
- Ignored transfers: HTRANS=IDLE or HSEL=0 or HREADY=0 with valid address → SRAMCS0=0, no write, HREADYOUT=1.
- Wrap: write 0x55 (word) to 0x0000_4004 → SRAMADDR=0x001; read 0x4 returns 0x00000055.

Source files
------------

// File: rtl/ahb_lite_sram_bridge_if.sv
// AHB-Lite bus bundle between the bus fabric and the SRAM bridge.
// The master modport is the interconnect side, the slave modport is the bridge.
interface ahb_lite_sram_bridge_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HREADY;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;

   modport master (
      output HSEL, HADDR, HREADY, HWRITE, HTRANS, HSIZE, HWDATA,
      input  HRDATA, HREADYOUT
   );

   modport slave (
      input  HSEL, HADDR, HREADY, HWRITE, HTRANS, HSIZE, HWDATA,
      output HRDATA, HREADYOUT
   );
endinterface

// File: rtl/ahb_lite_sram_bridge.sv
// AHB-Lite slave mapping a 2^AW byte window onto a 1-cycle sync SRAM.
// Writes land in the data phase; a read colliding with a pending write stalls once.
module ahb_lite_sram_bridge #(
   parameter int AW = 14
) (
   input  logic              HCLK,
   input  logic              HRESET,
   ahb_lite_sram_bridge_if.slave ahb,
   input  logic [31:0]       SRAMRDATA,
   output logic [3:0]        SRAMWEN,
   output logic [31:0]       SRAMWDATA,
   output logic              SRAMCS0,
   output logic [AW-3:0]     SRAMADDR
);

   logic          wr_pend;
   logic          rd_pend;
   logic          stall;
   logic [AW-3:0] wr_addr;
   logic [3:0]    wr_mask;

   logic          acc;
   logic          rd_ap;
   logic          collide;
   logic          wr_acc;
   logic          rd_issue;
   logic [3:0]    ap_mask;

   logic          unused_haddr;
   assign unused_haddr = ^ahb.HADDR[31:AW];

   assign acc      = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
   assign rd_ap    = ahb.HSEL & ahb.HTRANS[1] & ~ahb.HWRITE;
   assign collide  = wr_pend & rd_ap & ~stall;
   assign wr_acc   = acc & ahb.HWRITE;
   assign rd_issue = acc & ~ahb.HWRITE & ~wr_pend & ~collide;

   // Byte-lane mask for the transfer in its address phase.
   always_comb begin
      ap_mask = 4'b1111;
      unique case (1'b1)
         (ahb.HSIZE == 3'd0): ap_mask = 4'b0001 << ahb.HADDR[1:0];
         (ahb.HSIZE == 3'd1): ap_mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
         default:             ap_mask = 4'b1111;
      endcase
   end

   // SRAM port: pending write owns it, else a fresh read is issued.
   always_comb begin
      SRAMCS0   = 1'b0;
      SRAMWEN   = 4'b0000;
      SRAMADDR  = ahb.HADDR[AW-1:2];
      SRAMWDATA = ahb.HWDATA;
      if (!HRESET) begin
         if (wr_pend) begin
            SRAMCS0  = 1'b1;
            SRAMADDR = wr_addr;
            SRAMWEN  = wr_mask;
         end else if (rd_issue) begin
            SRAMCS0  = 1'b1;
         end
      end
   end

   // Bus responses: read data only in a read data phase, stall on collision.
   always_comb begin
      ahb.HRDATA    = rd_pend ? SRAMRDATA : 32'h0;
      ahb.HREADYOUT = ~collide;
   end

   // Pending-transfer flags; a write clears unless another is accepted.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wr_pend <= 1'b0;
         rd_pend <= 1'b0;
         stall   <= 1'b0;
      end else begin
         wr_pend <= wr_acc & ~collide;
         rd_pend <= rd_issue;
         stall   <= collide;
      end
   end

   // Write address and lane mask captured in the write address phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wr_addr <= '0;
         wr_mask <= 4'b0000;
      end else if (wr_acc) begin
         wr_addr <= ahb.HADDR[AW-1:2];
         wr_mask <= ap_mask;
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_bridge.sv
// Directed bench for ahb_lite_sram_bridge with a behavioural SRAM model.
// Expected values are hand-computed constants.
module tb_ahb_lite_sram_bridge;

   logic        HCLK;
   logic        HRESET;
   logic        hready_en;
   logic [31:0] sram_rdata;
   logic [3:0]  sram_wen;
   logic [31:0] sram_wdata;
   logic        sram_cs;
   logic [11:0] sram_addr;
   logic [31:0] mem [0:4095];

   int n_chk;
   int n_err;

   ahb_lite_sram_bridge_if bus();

   assign bus.HREADY = bus.HREADYOUT & hready_en;

   ahb_lite_sram_bridge #(.AW(14)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .ahb       (bus.slave),
      .SRAMRDATA (sram_rdata),
      .SRAMWEN   (sram_wen),
      .SRAMWDATA (sram_wdata),
      .SRAMCS0   (sram_cs),
      .SRAMADDR  (sram_addr)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Single-port synchronous SRAM with byte enables.
   always @(posedge HCLK) begin
      if (sram_cs) begin
         for (int i = 0; i < 4; i++)
            if (sram_wen[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
         if (sram_wen == 4'b0000) sram_rdata <= mem[sram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic smp();
      @(negedge HCLK);
   endtask

   task automatic ap(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a);
      bus.HSEL   = sel;
      bus.HTRANS = tr;
      bus.HWRITE = wr;
      bus.HSIZE  = sz;
      bus.HADDR  = a;
   endtask

   task automatic idle();
      ap(1'b1, 2'b00, 1'b0, 3'd0, 32'h0);
   endtask

   task automatic ahb_wr(input logic [31:0] a, input logic [31:0] d);
      ap(1'b1, 2'b10, 1'b1, 3'd2, a);
      cyc();
      bus.HWDATA = d;
      idle();
      cyc();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      hready_en = 1'b1;
      bus.HWDATA = 32'h0;
      idle();
      HRESET = 1'b1;

      // Reset held for two cycles.
      cyc();
      cyc();
      HRESET = 1'b0;
      smp();
      chk("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
      chk("rst_cs", {31'h0, sram_cs}, 32'h0);
      chk("rst_wen", {28'h0, sram_wen}, 32'h0);
      chk("rst_hrdata", bus.HRDATA, 32'h0);

      // Write in flight when reset hits must not reach the SRAM.
      cyc();
      ahb_wr(32'h14, 32'h12345678);
      ap(1'b1, 2'b10, 1'b1, 3'd2, 32'h14);
      cyc();
      bus.HWDATA = 32'hFFFFFFFF;
      idle();
      HRESET = 1'b1;
      smp();
      chk("rstmid_wen", {28'h0, sram_wen}, 32'h0);
      chk("rstmid_cs", {31'h0, sram_cs}, 32'h0);
      cyc();
      HRESET = 1'b0;
      ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h14);
      smp();
      chk("rstmid_rdaddr", {20'h0, sram_addr}, 32'h5);
      cyc();
      idle();
      smp();
      chk("rstmid_nowrite", bus.HRDATA, 32'h12345678);

      // Word write then read of the same address with one stall cycle.
      cyc();
      ap(1'b1, 2'b10, 1'b1, 3'd2, 32'h10);
      smp();
      chk("ww_ap_rdy", {31'h0, bus.HREADYOUT}, 32'h1);
      cyc();
      bus.HWDATA = 32'hDEADBEEF;
      ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h10);
      smp();
      chk("ww_addr", {20'h0, sram_addr}, 32'h4);
      chk("ww_wen", {28'h0, sram_wen}, 32'hF);
      chk("ww_cs", {31'h0, sram_cs}, 32'h1);
      chk("ww_stall", {31'h0, bus.HREADYOUT}, 32'h0);
      cyc();
      smp();
      chk("ww_unstall", {31'h0, bus.HREADYOUT}, 32'h1);
      chk("ww_nodouble", {28'h0, sram_wen}, 32'h0);
      chk("ww_rdissue", {19'h0, sram_cs, sram_addr}, 32'h1004);
      cyc();
      idle();
      smp();
      chk("ww_rdata", bus.HRDATA, 32'hDEADBEEF);

      // Byte and halfword lanes over a preloaded word.
      cyc();
      ahb_wr(32'h20, 32'h11223344);
      ap(1'b1, 2'b10, 1'b1, 3'd0, 32'h21);
      cyc();
      bus.HWDATA = 32'h0000AA00;
      ap(1'b1, 2'b10, 1'b1, 3'd0, 32'h22);
      smp();
      chk("b21_wen", {28'h0, sram_wen}, 32'h2);
      chk("b21_addr", {20'h0, sram_addr}, 32'h8);
      chk("b2b_rdy", {31'h0, bus.HREADYOUT}, 32'h1);
      cyc();
      bus.HWDATA = 32'h00220000;
      ap(1'b1, 2'b10, 1'b1, 3'd1, 32'h22);
      smp();
      chk("b22_wen", {28'h0, sram_wen}, 32'h4);
      cyc();
      bus.HWDATA = 32'h11220000;
      ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h20);
      smp();
      chk("h22_wen", {28'h0, sram_wen}, 32'hC);
      chk("h22_stall", {31'h0, bus.HREADYOUT}, 32'h0);
      cyc();
      smp();
      chk("lane_unstall", {31'h0, bus.HREADYOUT}, 32'h1);
      cyc();
      idle();
      smp();
      chk("lane_rdata", bus.HRDATA, 32'h1122AA44);

      // Pipelined reads NONSEQ, SEQ, SEQ.
      cyc();
      ahb_wr(32'h0, 32'hA0A0A0A0);
      ahb_wr(32'h4, 32'hA1A1A1A1);
      ahb_wr(32'h8, 32'hA2A2A2A2);
      ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h0);
      smp();
      chk("p0_rdy", {31'h0, bus.HREADYOUT}, 32'h1);
      chk("p0_issue", {19'h0, sram_cs, sram_addr}, 32'h1000);
      cyc();
      ap(1'b1, 2'b11, 1'b0, 3'd2, 32'h4);
      smp();
      chk("p1_rdy", {31'h0, bus.HREADYOUT}, 32'h1);
      chk("p0_data", bus.HRDATA, 32'hA0A0A0A0);
      cyc();
      ap(1'b1, 2'b11, 1'b0, 3'd2, 32'h8);
      smp();
      chk("p2_rdy", {31'h0, bus.HREADYOUT}, 32'h1);
      chk("p1_data", bus.HRDATA, 32'hA1A1A1A1);
      cyc();
      idle();
      smp();
      chk("p2_data", bus.HRDATA, 32'hA2A2A2A2);
      cyc();
      smp();
      chk("p_idle_hrdata", bus.HRDATA, 32'h0);

      // Ignored transfers: IDLE, unselected, HREADY low.
      cyc();
      ahb_wr(32'h40, 32'hCAFEF00D);
      ap(1'b1, 2'b00, 1'b1, 3'd2, 32'h40);
      smp();
      chk("ign_idle_cs", {31'h0, sram_cs}, 32'h0);
      chk("ign_idle_rdy", {31'h0, bus.HREADYOUT}, 32'h1);
      cyc();
      bus.HWDATA = 32'hFFFFFFFF;
      ap(1'b0, 2'b10, 1'b1, 3'd2, 32'h40);
      smp();
      chk("ign_idle_wen", {28'h0, sram_wen}, 32'h0);
      cyc();
      hready_en = 1'b0;
      ap(1'b1, 2'b10, 1'b1, 3'd2, 32'h40);
      smp();
      chk("ign_nsel_wen", {28'h0, sram_wen}, 32'h0);
      cyc();
      hready_en = 1'b1;
      idle();
      smp();
      chk("ign_nrdy_wen", {28'h0, sram_wen}, 32'h0);
      chk("ign_nrdy_rdy", {31'h0, bus.HREADYOUT}, 32'h1);
      cyc();
      ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h40);
      cyc();
      idle();
      smp();
      chk("ign_mem", bus.HRDATA, 32'hCAFEF00D);

      // Address above the window wraps modulo 16 KB.
      cyc();
      ap(1'b1, 2'b10, 1'b1, 3'd2, 32'h4004);
      cyc();
      bus.HWDATA = 32'h00000055;
      idle();
      smp();
      chk("wrap_addr", {20'h0, sram_addr}, 32'h1);
      chk("wrap_wen", {28'h0, sram_wen}, 32'hF);
      cyc();
      ap(1'b1, 2'b10, 1'b0, 3'd2, 32'h4);
      cyc();
      idle();
      smp();
      chk("wrap_rdata", bus.HRDATA, 32'h00000055);

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
